// File: rtl/tmc_pkg.sv
// Shared types and instruction-field layout for the Turing-machine controller.
package tmc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LAT,
        S_IF,
        S_EX,
        S_HALT
    } tmc_fsm_e;

    localparam int WSYM_BIT = 0;
    localparam int DIR_BIT  = 1;
    localparam int HALT_BIT = 2;
    localparam int NEXT_LSB = 3;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/tm_controller_if.sv
// Memory-side bus of the controller: instruction-memory fetch and tape read/write.
interface tm_controller_if #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 14
);
    logic [MEM_SIZE-1:0]   inst_addr;
    logic [DATA_WIDTH-1:0] inst_data;
    logic [MEM_SIZE-1:0]   tape_addr;
    logic                  tape_rdata;
    logic                  tape_wdata;
    logic                  tape_we;

    modport master (
        output inst_addr, tape_addr, tape_wdata, tape_we,
        input  inst_data, tape_rdata
    );

    modport slave (
        input  inst_addr, tape_addr, tape_wdata, tape_we,
        output inst_data, tape_rdata
    );
endinterface

// File: rtl/tmc_head_stepper.sv
// Combinational head move by +1 or -1, wrapping modulo 2^MEM_SIZE.
module tmc_head_stepper
    import tmc_pkg::*;
#(
    parameter int MEM_SIZE = 14
) (
    input  logic [MEM_SIZE-1:0] head,
    input  logic                dir,
    output logic [MEM_SIZE-1:0] head_nxt
);
    logic [MEM_SIZE-1:0] step;

    // -1 is all ones, so a single adder covers both directions and the wrap.
    assign step     = (dir == DIR_RIGHT) ? {{(MEM_SIZE-1){1'b0}}, 1'b1} : {MEM_SIZE{1'b1}};
    assign head_nxt = head + step;
endmodule

// File: rtl/tm_controller.sv
// Turing-machine sequencing FSM: tape read, transition fetch, write/move/next-state.
// Optional macro TMC_STEP_LIMIT_EN adds a per-run step limit that forces HALT.
module tm_controller
    import tmc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 14,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [MEM_SIZE-1:0]   head_init,
`ifdef TMC_STEP_LIMIT_EN
    input  logic [CNT_WIDTH-1:0]  step_limit,
    output logic                  limit_hit,
`endif
    output logic                  busy,
    output logic                  halted,
    output logic [MEM_SIZE-2:0]   state,
    output logic [MEM_SIZE-1:0]   head,
    output logic [CNT_WIDTH-1:0]  step_count,
    tm_controller_if.master       mem
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    tmc_fsm_e              fsm;
    logic                  sym;
    logic                  ex_halt;
    logic                  ex_dir;
    logic [MEM_SIZE-2:0]   ex_next;
    logic [MEM_SIZE-1:0]   head_nxt;
    logic [CNT_WIDTH-1:0]  cnt_nxt;
    logic                  unused_inst_bits;

    assign ex_halt = mem.inst_data[HALT_BIT];
    assign ex_dir  = mem.inst_data[DIR_BIT];
    assign ex_next = mem.inst_data[NEXT_LSB +: (MEM_SIZE-1)];
    assign cnt_nxt = sat_inc(step_count);

    generate
        if (DATA_WIDTH > MEM_SIZE + 2) begin : g_spare
            assign unused_inst_bits = ^mem.inst_data[DATA_WIDTH-1:MEM_SIZE+2];
        end else begin : g_nospare
            assign unused_inst_bits = 1'b0;
        end
    endgenerate

    tmc_head_stepper #(.MEM_SIZE(MEM_SIZE)) u_stepper (
        .head     (head),
        .dir      (ex_dir),
        .head_nxt (head_nxt)
    );

`ifdef TMC_STEP_LIMIT_EN
    logic [CNT_WIDTH-1:0] limit_q;
    logic                 limit_reached;
    assign limit_reached = (limit_q != '0) && (cnt_nxt == limit_q);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm        <= S_IDLE;
            state      <= '0;
            head       <= '0;
            step_count <= '0;
            sym        <= 1'b0;
`ifdef TMC_STEP_LIMIT_EN
            limit_q    <= '0;
            limit_hit  <= 1'b0;
`endif
        end else begin
            case (fsm)
                // A finished run restarts straight from HALT with the same captures as IDLE.
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state      <= '0;
                        head       <= head_init;
                        step_count <= '0;
`ifdef TMC_STEP_LIMIT_EN
                        limit_q    <= step_limit;
                        limit_hit  <= 1'b0;
`endif
                        fsm        <= S_RD;
                    end
                end
                S_RD:  fsm <= S_LAT;
                S_LAT: begin
                    sym <= mem.tape_rdata;
                    fsm <= S_IF;
                end
                S_IF:  fsm <= S_EX;
                S_EX: begin
                    step_count <= cnt_nxt;
                    if (ex_halt) begin
                        fsm <= S_HALT;
                    end else begin
                        head  <= head_nxt;
                        state <= ex_next;
`ifdef TMC_STEP_LIMIT_EN
                        if (limit_reached) begin
                            limit_hit <= 1'b1;
                            fsm       <= S_HALT;
                        end else begin
                            fsm <= S_RD;
                        end
`else
                        fsm <= S_RD;
`endif
                    end
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end

    assign busy           = (fsm == S_RD) || (fsm == S_LAT) || (fsm == S_IF) || (fsm == S_EX);
    assign halted         = (fsm == S_HALT);
    assign mem.inst_addr  = {state, sym};
    assign mem.tape_addr  = head;
    assign mem.tape_we    = (fsm == S_EX) && !rst;
    assign mem.tape_wdata = (fsm == S_EX) ? mem.inst_data[WSYM_BIT] : 1'b0;

endmodule

// File: doc/tm_controller.md
Name: tm_controller

Overview:
- Sequencing FSM for the Turing-machine datapath: instruction memory, tape (input) memory, state pointer and head pointer.
- Per step it:
  - reads the tape symbol under the head;
  - fetches the transition for (state, symbol);
  - writes the new symbol;
  - moves the head ±1;
  - loads the next state, until a halt transition.
- Sits between the top-level machine and the two synchronous-read memories; owns all address, write-enable and pointer updates.

Parameters:
DATA_WIDTH, 32, instruction word width
MEM_SIZE, 14, address width of both memories; state register is MEM_SIZE-1 bits
CNT_WIDTH, 32, step counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  begin a run; sampled in IDLE or HALT only
head_init  in  MEM_SIZE  initial head position, captured on start
busy  out  1  high while a run is in progress
halted  out  1  high in HALT until next start or rst
inst_addr  out  MEM_SIZE  instruction memory address = {state, sym}
inst_data  in  DATA_WIDTH  instruction memory read data, valid 1 cycle after inst_addr
tape_addr  out  MEM_SIZE  tape address, always = head
tape_rdata  in  1  tape read data, valid 1 cycle after tape_addr
tape_wdata  out  1  symbol to write
tape_we  out  1  tape write enable
state  out  MEM_SIZE-1  current machine state
head  out  MEM_SIZE  current head position
step_count  out  CNT_WIDTH  completed transitions in this run

Behaviour:
- Instruction fields:
  - bit0 = write symbol
  - bit1 = direction (1 = +1/right, 0 = -1/left)
  - bit2 = halt
  - bits[MEM_SIZE+1:3] = next state (MEM_SIZE-1 bits)
  - remaining bits ignored
- Reset values: FSM=IDLE, state=0, head=0, step_count=0, busy=0, halted=0, tape_we=0, tape_wdata=0, sym latch=0.
- All outputs are registered or decoded from FSM state only. tape_we is additionally gated by !rst, so no write occurs in a reset cycle.
- FSM states: IDLE, RD, LAT, IF, EX, HALT.
  - IDLE: busy=0. On start: state<=0, head<=head_init, step_count<=0, ->RD.
  - RD: busy=1; tape_addr=head; ->LAT.
  - LAT: sym<=tape_rdata; ->IF.
  - IF: inst_addr={state,sym}; ->EX.
  - EX: tape_we=1, tape_wdata=inst_data[0] at tape_addr=head.
    - step_count<=step_count+1, saturating at all ones.
    - If inst_data[2]=1: head and state unchanged, ->HALT.
    - Otherwise: head<=head±1 modulo 2^MEM_SIZE, state<=next-state field, ->RD.
  - HALT: halted=1, busy=0. start ->IDLE-equivalent restart, i.e. same captures as IDLE start, direct ->RD.
- Latency:
  - 4 cycles per transition.
  - busy rises the cycle after start is sampled.
  - halted rises the cycle after EX of the halt transition.
- Boundaries:
  - Head wrap: head=0 moving left ->2^MEM_SIZE-1; head=2^MEM_SIZE-1 moving right ->0.
  - start while busy: ignored.
  - start and rst in the same cycle: rst wins.
  - rst mid-run (any state): back to IDLE next edge with reset values; the tape write in that cycle is suppressed.
  - State field exceeding 2^(MEM_SIZE-1)-1 cannot occur (width-truncated by construction).

Optional Feature:
- Macro TMC_STEP_LIMIT_EN.
- With the macro:
  - Adds input step_limit[CNT_WIDTH] (captured on start; 0 = unlimited) and output limit_hit.
  - If step_count reaches step_limit at EX of a non-halt transition, the FSM enters HALT instead of RD. The write and move still occur.
  - limit_hit=1 together with halted; cleared on start or rst.
- Without the macro: no such ports; runs only end via a halt bit or rst.

Decomposition:
- Shared package tmc_pkg:
  - FSM state enum;
  - instruction field bit positions (WSYM_BIT=0, DIR_BIT=1, HALT_BIT=2, NEXT_LSB=3);
  - DIR_LEFT/DIR_RIGHT constants.
- One natural sub-module: tmc_head_stepper, a combinational head ±1 with wrap, reusing the codebase adder and mux pattern.
- Everything else lives in tm_controller.

Test Plan:
- Reset values: rst=1 for 2 cycles -> all outputs 0, FSM idle, tape_we never asserted.
- Single-step halt: instruction memory word at addr {0,0} = 0x5 (write 1, left, halt), tape all 0, head_init=7, start -> tape[7]=1, halted=1 after 5 cycles from start, step_count=1, head=7.
- Multi-step run with wrap:
  - Program: state0 on sym0 -> write 1, move left, next state 1.
  - state1 on sym0 -> halt.
  - head_init=0, start -> tape[0]=1, head=0x3FFF, step_count=2, halted.
- Reset mid-run: assert rst during EX -> no tape write that cycle, busy=0, head=0, state=0 next cycle.
- Start while busy is ignored, restart from HALT works: second start from HALT with head_init=3 -> step_count reset to 0, busy=1 next cycle.
- TMC_STEP_LIMIT_EN: non-halting loop program, step_limit=5 -> halted=1, limit_hit=1, step_count=5, exactly 5 tape writes.
